// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Round-robin, burst-bounded sharing of one fifo write port among
//            NUM_REQ producers. Define FIFO_ARB_PRIORITY_EN to give req[0]
//            priority in IDLE and let it pre-empt other owners mid-burst.
// Revision : 1.0  initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ITEM_SIZE_BITS = 32,
    parameter int MAX_BURST      = 4
) (
    input  logic                              CLOCK_50,
    input  logic                              RST,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*ITEM_SIZE_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]                ack,
    output logic [ITEM_SIZE_BITS-1:0]         fifo_data_in,
    output logic                              fifo_write,
    input  logic                              fifo_full,
    output logic                              busy,
    output logic [$clog2(NUM_REQ)-1:0]        owner
);

    localparam int              C_OWNER_W   = $clog2(NUM_REQ);
    localparam int              C_BEAT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [C_BEAT_W-1:0]  C_LAST_BEAT = C_BEAT_W'(MAX_BURST - 1);
    localparam logic [C_OWNER_W-1:0] C_LAST_REQ  = C_OWNER_W'(NUM_REQ - 1);

    localparam logic [0:0] C_ST_IDLE  = 1'b0;
    localparam logic [0:0] C_ST_BURST = 1'b1;

    logic [0:0]           r_state;
    logic [C_OWNER_W-1:0] r_owner;
    logic [C_OWNER_W-1:0] r_rr_ptr;
    logic [C_BEAT_W-1:0]  r_beat_cnt;

    logic [0:0]           w_state_nxt;
    logic [C_OWNER_W-1:0] w_owner_nxt;
    logic [C_OWNER_W-1:0] w_rr_nxt;
    logic [C_BEAT_W-1:0]  w_beat_nxt;
    logic [C_OWNER_W-1:0] w_pick;
    logic                 w_found;
    logic                 w_end;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[C_OWNER_W'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                w_pick  = C_OWNER_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
`ifdef FIFO_ARB_PRIORITY_EN
        if (req[0]) begin
            w_pick = '0;
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            r_state    <= C_ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_end       = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = C_ST_BURST;
                    w_owner_nxt = w_pick;
                    w_beat_nxt  = '0;
                end
            end
            C_ST_BURST: begin
                if (!req[r_owner]) begin
                    w_end = 1'b1;
                end else if (!fifo_full) begin
                    if (r_beat_cnt == C_LAST_BEAT) begin
                        w_end = 1'b1;
                    end else begin
                        w_beat_nxt = r_beat_cnt + 1'b1;
                    end
                end
`ifdef FIFO_ARB_PRIORITY_EN
                if (r_owner != '0 && req[0]) begin
                    w_end = 1'b1;
                end
`endif
                if (w_end) begin
                    w_state_nxt = C_ST_IDLE;
                    w_rr_nxt    = (r_owner == C_LAST_REQ) ? '0 : r_owner + 1'b1;
                end
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while RST is held, even if a burst was in flight.
    always_comb begin
        ack          = '0;
        fifo_write   = 1'b0;
        fifo_data_in = '0;
        busy         = 1'b0;
        if (!RST && r_state == C_ST_BURST) begin
            busy = 1'b1;
            if (req[r_owner] && !fifo_full) begin
                ack[r_owner] = 1'b1;
                fifo_write   = 1'b1;
                fifo_data_in = req_data[int'(r_owner) * ITEM_SIZE_BITS +: ITEM_SIZE_BITS];
            end
        end
    end

    assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Vector table, directed corner sequences and random traffic
//            against a reference model for fifo_write_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;
    localparam int OW = 2;
`ifdef FIFO_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            CLOCK_50 = 1'b0;
    logic            RST;
    logic [N-1:0]    req;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    ack;
    logic [W-1:0]    fifo_data_in;
    logic            fifo_write;
    logic            fifo_full;
    logic            busy;
    logic [OW-1:0]   owner;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          rst;
        bit [N-1:0]  req;
        bit          full;
        bit [W-1:0]  d2;
        bit [N-1:0]  ack;
        bit          busy;
        bit [OW-1:0] own;
    } vec_t;

    always #5 CLOCK_50 = ~CLOCK_50;

    fifo_write_arbiter #(
        .NUM_REQ(N), .ITEM_SIZE_BITS(W), .MAX_BURST(MB)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RST          (RST),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_data_in (fifo_data_in),
        .fifo_write   (fifo_write),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .owner        (owner)
    );

    task automatic check(input string name, input bit [N-1:0] eack,
                         input bit ebusy, input bit [OW-1:0] eown);
        logic [W-1:0] edata;
        edata = '0;
        for (int i = 0; i < N; i++)
            if (eack[i]) edata = req_data[i*W +: W];
        checks++;
        if (ack !== eack || fifo_write !== (|eack) || busy !== ebusy ||
            owner !== eown || fifo_data_in !== edata) begin
            errors++;
            $display("FAIL %s t=%0t: got ack=%b write=%b busy=%b owner=%0d data=%h, want ack=%b write=%b busy=%b owner=%0d data=%h",
                     name, $time, ack, fifo_write, busy, owner, fifo_data_in,
                     eack, |eack, ebusy, eown, edata);
        end
    endtask

    task automatic drive(input bit r, input bit [N-1:0] q, input bit f);
        @(negedge CLOCK_50);
        RST = r; req = q; fifo_full = f;
        #1;
    endtask

    task automatic step(input string name, input bit r, input bit [N-1:0] q, input bit f,
                        input bit [N-1:0] eack, input bit ebusy, input bit [OW-1:0] eown);
        drive(r, q, f);
        check(name, eack, ebusy, eown);
    endtask

    // Reference model state
    bit          m_busy;
    int          m_owner, m_next, m_words;
    bit [N-1:0]  act;
    bit [W-1:0]  dat [N];

    initial begin
        vec_t tbl [16];
        tbl = '{
            '{1'b1, 4'hF, 1'b0, 32'hC2, 4'h0, 1'b0, 2'd0},
            '{1'b1, 4'hF, 1'b0, 32'hC2, 4'h0, 1'b0, 2'd0},
            '{1'b0, 4'hF, 1'b0, 32'hC2, 4'h0, 1'b0, 2'd0},
            '{1'b0, 4'hF, 1'b0, 32'hC2, 4'h1, 1'b1, 2'd0},
            '{1'b1, 4'h0, 1'b0, 32'hC2, 4'h0, 1'b0, 2'd0},
            '{1'b0, 4'h4, 1'b0, 32'hA0, 4'h0, 1'b0, 2'd0},
            '{1'b0, 4'h4, 1'b0, 32'hA0, 4'h4, 1'b1, 2'd2},
            '{1'b0, 4'h4, 1'b0, 32'hA1, 4'h4, 1'b1, 2'd2},
            '{1'b0, 4'h4, 1'b0, 32'hA2, 4'h4, 1'b1, 2'd2},
            '{1'b0, 4'h4, 1'b0, 32'hA3, 4'h4, 1'b1, 2'd2},
            '{1'b0, 4'h4, 1'b0, 32'hA4, 4'h0, 1'b0, 2'd2},
            '{1'b0, 4'h4, 1'b0, 32'hA4, 4'h4, 1'b1, 2'd2},
            '{1'b0, 4'h4, 1'b0, 32'hA5, 4'h4, 1'b1, 2'd2},
            '{1'b0, 4'h4, 1'b0, 32'hA6, 4'h4, 1'b1, 2'd2},
            '{1'b0, 4'h4, 1'b0, 32'hA7, 4'h4, 1'b1, 2'd2},
            '{1'b0, 4'h0, 1'b0, 32'hC2, 4'h0, 1'b0, 2'd2}
        };

        RST = 1'b1; req = '0; fifo_full = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hC0 + i;
        @(posedge CLOCK_50);

        // Reset behaviour and single-requester bursts
        for (int i = 0; i < 16; i++) begin
            @(negedge CLOCK_50);
            RST = tbl[i].rst; req = tbl[i].req; fifo_full = tbl[i].full;
            req_data[2*W +: W] = tbl[i].d2;
            #1;
            check($sformatf("vec%0d", i), tbl[i].ack, tbl[i].busy, tbl[i].own);
        end
        req_data[2*W +: W] = 32'hC2;

        // All requesting: rotation 0,1,2,3,0 (req[0] always wins with priority)
        step("rst_a", 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2);
        for (int g = 0; g < 5; g++) begin
            step("rr_idle", 1'b0, 4'hF, 1'b0, 4'h0, 1'b0,
                 (g == 0 || PRIO) ? 2'd0 : 2'((g - 1) % 4));
            for (int b = 0; b < MB; b++)
                step("rr_beat", 1'b0, 4'hF, 1'b0,
                     PRIO ? 4'h1 : 4'(1 << (g % 4)), 1'b1,
                     PRIO ? 2'd0 : 2'(g % 4));
        end

        // fifo_full stall after two beats of owner 1
        step("full_idle", 1'b0, 4'hE, 1'b0, 4'h0, 1'b0, 2'd0);
        for (int b = 0; b < 2; b++) step("full_beat", 1'b0, 4'hE, 1'b0, 4'h2, 1'b1, 2'd1);
        for (int s = 0; s < 3; s++) step("full_stall", 1'b0, 4'hE, 1'b1, 4'h0, 1'b1, 2'd1);
        for (int b = 0; b < 2; b++) step("full_tail", 1'b0, 4'hE, 1'b0, 4'h2, 1'b1, 2'd1);
        step("full_done", 1'b0, 4'hE, 1'b0, 4'h0, 1'b0, 2'd1);

        // Early drop by owner 1, then rr_ptr=2 selects 3 over 1
        step("rst_c", 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2);
        step("drop_idle", 1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 2'd0);
        for (int b = 0; b < 2; b++) step("drop_beat", 1'b0, 4'h2, 1'b0, 4'h2, 1'b1, 2'd1);
        step("drop_cycle", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1);
        step("drop_idle2", 1'b0, 4'hA, 1'b0, 4'h0, 1'b0, 2'd1);
        step("drop_next", 1'b0, 4'hA, 1'b0, 4'h8, 1'b1, 2'd3);

        // req[0] rises during owner 2's burst
        step("rst_d", 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd3);
        step("pr_idle", 1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 2'd0);
        step("pr_beat1", 1'b0, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2);
        step("pr_beat2", 1'b0, 4'h5, 1'b0, 4'h4, 1'b1, 2'd2);
`ifndef FIFO_ARB_PRIORITY_EN
        step("pr_beat3", 1'b0, 4'h5, 1'b0, 4'h4, 1'b1, 2'd2);
        step("pr_beat4", 1'b0, 4'h5, 1'b0, 4'h4, 1'b1, 2'd2);
`endif
        step("pr_exit", 1'b0, 4'h5, 1'b0, 4'h0, 1'b0, 2'd2);
        step("pr_grant0", 1'b0, 4'h5, 1'b0, 4'h1, 1'b1, 2'd0);

        // Random traffic against the reference model
        step("rst_r", 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
        m_busy = 1'b0; m_owner = 0; m_next = 0; m_words = 0; act = '0;
        for (int i = 0; i < N; i++) dat[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            bit          r, f, done, found;
            bit [N-1:0]  eack;
            bit          ebusy;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 3) == 0);
            @(negedge CLOCK_50);
            RST = r; req = act; fifo_full = f;
            for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
            #1;
            ebusy = !r && m_busy;
            eack  = (ebusy && act[m_owner] && !f) ? 4'(1 << m_owner) : 4'h0;
            check("rand", eack, ebusy, 2'(m_owner));

            if (r) begin
                m_busy = 1'b0; m_owner = 0; m_next = 0; m_words = 0;
            end else if (!m_busy) begin
                if (act != 0) begin
                    found = 1'b0;
                    if (PRIO && act[0]) begin
                        m_owner = 0; found = 1'b1;
                    end
                    for (int k = 0; k < N; k++)
                        if (!found && act[(m_next + k) % N]) begin
                            m_owner = (m_next + k) % N; found = 1'b1;
                        end
                    m_busy = 1'b1; m_words = 0;
                end
            end else begin
                done = 1'b0;
                if (!act[m_owner]) done = 1'b1;
                else if (!f) begin
                    m_words++;
                    if (m_words == MB) done = 1'b1;
                end
                if (PRIO && m_owner != 0 && act[0]) done = 1'b1;
                if (done) begin
                    m_busy = 1'b0;
                    m_next = (m_owner + 1) % N;
                end
            end

            if (!r) begin
                for (int i = 0; i < N; i++) begin
                    if (eack[i]) begin
                        dat[i] = $urandom;
                        act[i] = ($urandom_range(0, 3) != 0);
                    end else if (!act[i]) begin
                        act[i] = ($urandom_range(0, 2) == 0);
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
